// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed for a counter that runs 0 .. width-1.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
// The master side supplies operands and consumes results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_a, in_b, in_valid, out_ready,
        input  in_ready, out_diff, out_borrow, out_valid
    );

    modport slave (
        input  in_a, in_b, in_valid, out_ready,
        output in_ready, out_diff, out_borrow, out_valid
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Difference bit and borrow-out of a single column.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are shifted out LSB first through a
// single full-subtractor cell; the borrow is carried between cycles in a register
// and difference bits are shifted into the result register from the MSB end.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == LAST_CNT);

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH processing cycles in BUSY,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)        w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: handshake flags decode the state only; data comes straight from registers.
    always_comb begin
        bus.in_ready   = (r_state == ST_IDLE);
        bus.out_valid  = (r_state == ST_DONE);
        bus.out_diff   = r_res;
        bus.out_borrow = r_borrow;
    end

    // Datapath: load operands on accept, then shift one bit per BUSY cycle.
    // The borrow register doubles as the final borrow once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == ST_BUSY) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_res    <= {w_d, r_res[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=3 (directed + exhaustive)
// and WIDTH=8 (random), against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   prev_out = -1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(3)) if3 ();
    serial_subtractor_if #(.WIDTH(8)) if8 ();

    serial_subtractor #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: low WIDTH bits of a-b, and borrow iff a<b.
    function automatic int ref_diff(input int a, input int b, input int w);
        return (a - b + (1 << w)) % (1 << w);
    endfunction

    // One WIDTH=3 transaction with optional stall, optional ignored in_valid poke,
    // and optional in_valid held high (back-to-back mode with spacing check).
    task automatic xact3(input int a, input int b, input int stall, input bit poke,
                         input bit keep_valid, input string tag);
        int t0;
        int n;
        int ed;
        int eb;
        bit seen;
        ed = ref_diff(a, b, 3);
        eb = (a < b) ? 1 : 0;
        if3.in_a      = 3'(a);
        if3.in_b      = 3'(b);
        if3.in_valid  = 1'b1;
        if3.out_ready = (stall == 0);
        n = 0;
        while (!if3.in_ready && n < 20) begin tick(); n++; end
        tick();
        t0 = cyc;
        if (!keep_valid) if3.in_valid = 1'b0;
        n = 0;
        while (!if3.out_valid && n < 20) begin tick(); n++; end
        chk({tag, "_lat"}, cyc - t0, 3);
        chk({tag, "_diff"}, if3.out_diff, ed);
        chk({tag, "_borrow"}, if3.out_borrow, eb);
        chk({tag, "_inrdy_done"}, if3.in_ready, 0);
        if (keep_valid && prev_out >= 0) chk({tag, "_spacing"}, cyc - prev_out, 5);
        prev_out = cyc;
        for (int s = 0; s < stall; s++) begin
            if (poke && s == stall / 2) begin
                if3.in_valid = 1'b1;
                if3.in_a     = 3'($urandom_range(0, 7));
                if3.in_b     = 3'($urandom_range(0, 7));
            end else begin
                if3.in_valid = 1'b0;
            end
            tick();
            chk({tag, "_hold_valid"}, if3.out_valid, 1);
            chk({tag, "_hold_diff"}, if3.out_diff, ed);
            chk({tag, "_hold_borrow"}, if3.out_borrow, eb);
            chk({tag, "_hold_inrdy"}, if3.in_ready, 0);
        end
        if (!keep_valid) if3.in_valid = 1'b0;
        if3.out_ready = 1'b1;
        tick();
        chk({tag, "_xfer_valid"}, if3.out_valid, 0);
        chk({tag, "_xfer_inrdy"}, if3.in_ready, 1);
        if3.out_ready = keep_valid;
        if (poke) begin
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (if3.out_valid) seen = 1'b1;
            end
            chk({tag, "_no_ghost"}, seen, 0);
        end
    endtask

    // One WIDTH=8 transaction with a random output stall.
    task automatic xact8(input int a, input int b, input int stall);
        int t0;
        int n;
        if8.in_a      = 8'(a);
        if8.in_b      = 8'(b);
        if8.in_valid  = 1'b1;
        if8.out_ready = (stall == 0);
        n = 0;
        while (!if8.in_ready && n < 30) begin tick(); n++; end
        tick();
        t0 = cyc;
        if8.in_valid = 1'b0;
        n = 0;
        while (!if8.out_valid && n < 30) begin tick(); n++; end
        chk("w8_lat", cyc - t0, 8);
        for (int s = 0; s < stall; s++) tick();
        chk("w8_diff", if8.out_diff, ref_diff(a, b, 8));
        chk("w8_borrow", if8.out_borrow, (a < b) ? 1 : 0);
        if8.out_ready = 1'b1;
        tick();
        chk("w8_xfer_valid", if8.out_valid, 0);
        if8.out_ready = 1'b0;
        $display("w8 a=%0d b=%0d stall=%0d -> diff=%0d borrow=%0d", a, b, stall,
                 ref_diff(a, b, 8), (a < b) ? 1 : 0);
    endtask

    initial begin
        bit seen;
        int pa[3];
        int pb[3];
        if3.in_a = '0; if3.in_b = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b0;
        if8.in_a = '0; if8.in_b = '0; if8.in_valid = 1'b0; if8.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_inrdy", if3.in_ready, 1);
        chk("rst_valid", if3.out_valid, 0);
        chk("rst_diff", if3.out_diff, 0);
        chk("rst_borrow", if3.out_borrow, 0);
        chk("rst8_inrdy", if8.in_ready, 1);
        rst = 1'b0;
        tick();

        // Directed cases.
        xact3(5, 3, 0, 0, 0, "d53");   $display("w3 a=5 b=3");
        xact3(3, 5, 0, 0, 0, "d35");   $display("w3 a=3 b=5");
        xact3(0, 7, 0, 0, 0, "d07");   $display("w3 a=0 b=7");
        xact3(0, 0, 0, 0, 0, "d00");   $display("w3 a=0 b=0");
        xact3(7, 2, 5, 1, 0, "bp72");  $display("w3 a=7 b=2 backpressure");

        // Reset in the second BUSY cycle discards the partial result.
        if3.in_a = 3'd6; if3.in_b = 3'd1; if3.in_valid = 1'b1; if3.out_ready = 1'b1;
        tick();
        if3.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_inrdy", if3.in_ready, 1);
        chk("rstmid_valid", if3.out_valid, 0);
        chk("rstmid_diff", if3.out_diff, 0);
        chk("rstmid_borrow", if3.out_borrow, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if3.out_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid", seen, 0);
        $display("w3 a=6 b=1 reset mid-busy");
        xact3(4, 4, 0, 0, 0, "d44");   $display("w3 a=4 b=4");

        // Back-to-back with in_valid held high.
        pa[0] = 1; pb[0] = 0; pa[1] = 2; pb[1] = 3; pa[2] = 7; pb[2] = 7;
        prev_out = -1;
        if3.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xact3(pa[i], pb[i], 0, 0, 1, "b2b");
            $display("w3 b2b a=%0d b=%0d", pa[i], pb[i]);
        end
        if3.in_valid  = 1'b0;
        if3.out_ready = 1'b0;
        tick();

        // Exhaustive at WIDTH=3 with random output stalls.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                xact3(a, b, $urandom_range(0, 2), 0, 0, "exh");
                $display("w3 exh a=%0d b=%0d", a, b);
            end
        end

        // Random at WIDTH=8.
        for (int i = 0; i < 40; i++) begin
            xact8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
        end
        xact8(0, 255, 0);
        xact8(255, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `in_a - in_b` one bit per clock through a single full-subtractor cell, with a registered borrow chain. It is the inverse-direction companion to the team's combinational ripple adder: the same full-cell decomposition, reversed in arithmetic sense and sequenced in time. Operands enter through a valid/ready handshake and results leave through one. It sits in the lab datapath wherever subtraction is needed and area matters more than latency.

## Interface
- `WIDTH`, default 3: operand width in bits. Legal range is WIDTH ≥ 2.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_a` input WIDTH: minuend, unsigned.
- `in_b` input WIDTH: subtrahend, unsigned.
- `in_valid` input 1: operands are valid.
- `in_ready` output 1: the block can accept operands.
- `out_diff` output WIDTH: (a − b) mod 2^WIDTH.
- `out_borrow` output 1: 1 iff a < b.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer accepts the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch a and b into shift registers, clear the borrow register to 0, clear the bit counter to 0, go to BUSY.
- **BUSY**
  - `in_ready`=0, `out_valid`=0. `in_valid` is ignored.
  - Each cycle the LSB of each shift register feeds the cell together with the borrow register.
  - The cell's difference bit shifts into the MSB of the result register (right shift). The cell's borrow-out loads the borrow register.
  - The counter increments each cycle. When the counter reaches WIDTH−1 on that edge, go to DONE.
- **DONE**
  - `out_valid`=1. `out_diff` = result register. `out_borrow` = final borrow.
  - On `out_valid && out_ready`: go to IDLE.
  - The block does not accept new operands until the edge after the transfer, so results never overlap.
- **Cell equations**
  - d = a ^ b ^ bin.
  - bout = (~a & b) | (~(a ^ b) & bin).
- **Arithmetic**
  - Unsigned only.
  - The result equals the low WIDTH bits of (a − b + 2^WIDTH).
  - `out_borrow` equals the inverted carry-out of a + ~b + 1.
- **Reset values** (all apply on any edge with `rst`=1, including mid-BUSY or mid-DONE; a partial result is discarded and never emitted):
  - state=IDLE, `in_ready`=1.
  - `out_valid`=0, `out_diff`=0, `out_borrow`=0.
  - shift registers, counter and borrow register all 0.

## Timing
- **Latency**: accept on edge k gives `out_valid` high in the cycle after edge k+WIDTH. Latency is exactly WIDTH cycles, independent of data.
- **Throughput**: at best one result per WIDTH+2 cycles (accept cycle, WIDTH BUSY cycles, one DONE cycle with `out_ready`=1).
- **Output stability**: `out_diff` and `out_borrow` are registered and hold stable for as long as `out_valid`=1 and `out_ready`=0.
- **Handshake rules**:
  - `out_valid` is not combinationally dependent on `out_ready`.
  - `in_ready` depends on state only.
- **Simultaneous reset**: `rst` together with a handshake (input or output): reset wins, and no transfer is deemed to occur.

## Structure
- Shared package or header `serial_subtractor_pkg` holds:
  - FSM state localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - The counter width function, $clog2(WIDTH).
- Sub-module `full_subtractor` (inputs a, b, bin; outputs d, bout): purely combinational, instantiated once.
- The top level contains the FSM, two operand shift registers, the result shift register, the borrow register and the counter.

## Test plan
- WIDTH=3. a=5, b=3, `out_ready`=1 → `out_valid` rises exactly 3 cycles after the accept edge with `out_diff`=2, `out_borrow`=0. The FSM then returns to IDLE and `in_ready`=1 on the following cycle.
- a=3, b=5 → `out_diff`=6, `out_borrow`=1. Also a=0, b=7 → `out_diff`=1, `out_borrow`=1. Also a=0, b=0 → 0, 0.
- Backpressure: a=7, b=2 with `out_ready` held low for 5 cycles → `out_valid`=1, `out_diff`=5 and `out_borrow`=0 stay stable, `in_ready`=0 throughout. A new `in_valid` pulse during this time is ignored. Transfer occurs on the first `out_ready`=1 cycle.
- Reset mid-BUSY: accept a=6, b=1, assert `rst` on the 2nd BUSY cycle → all outputs reach their reset values on the next edge and no `out_valid` pulse ever appears. Next transaction a=4, b=4 → 0, 0.
- Back-to-back: `in_valid` held high with `out_ready`=1 over pairs (1,0), (2,3), (7,7) → results (1,0), (7,1), (0,0) in order, each spaced WIDTH+2 cycles.
- Exhaustive check at WIDTH=3 (all 64 pairs) and random check at WIDTH=8 against the reference model {borrow, diff} = {a<b, (a−b) mod 2^WIDTH}, with random `out_ready` stalls.
